serial_adder_ctl: RTL and testbench

Bit-serial addition sequencer built around one external full-adder cell (XOR sum path, NAND carry path). It accepts two WIDTH-bit operands and a carry-in. It then streams one bit pair per clock through the cell, LSB first, and recirculates the carry through an internal flip-flop. It returns the WIDTH-bit sum and carry-out with a start/busy/done handshake. The block sits between a requesting controller and the shared full-adder cell, which it owns exclusively while busy.

---
 rtl/serial_adder_ctl_if.sv | 9 +
 rtl/serial_adder_ctl.sv | 74 +++++++
 tb/tb_serial_adder_ctl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctl_if.sv
// serial_adder_ctl_if: request/result handshake plus full-adder cell connections.
interface serial_adder_ctl_if #(parameter int WIDTH = 8);
  logic start, cin, busy, done, cout, fa_a, fa_b, fa_c, fa_s, fa_co;
  logic [WIDTH-1:0] a, b, sum;
  modport master(output start, a, b, cin, fa_s, fa_co,
                 input busy, done, sum, cout, fa_a, fa_b, fa_c);
  modport slave(input start, a, b, cin, fa_s, fa_co,
                output busy, done, sum, cout, fa_a, fa_b, fa_c);
endinterface

// File: rtl/serial_adder_ctl.sv
// serial_adder_ctl: bit-serial adder sequencer driving one external full-adder cell, LSB first.
module serial_adder_ctl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic reset,
  serial_adder_ctl_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, res_q, res_d;
  logic [WIDTH:0] cat;
  logic c_q, c_d, rco_q, rco_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run;
  assign run = state_q == RUN;
  assign bus.busy = run;
  assign bus.done = state_q == DONE;
  assign bus.fa_a = run & a_q[0];
  assign bus.fa_b = run & b_q[0];
  assign bus.fa_c = run & c_q;
  // result registers keep the previous answer visible while a new one streams in
  assign bus.sum = res_q;
  assign bus.cout = rco_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    c_d = c_q;
    cnt_d = cnt_q;
    res_d = res_q;
    rco_d = rco_q;
    cat = {bus.fa_s, s_q};
    if (run) begin
      s_d = cat[WIDTH:1];
      c_d = bus.fa_co;
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        res_d = cat[WIDTH:1];
        rco_d = bus.fa_co;
      end
    end else if (bus.start) begin
      a_d = bus.a;
      b_d = bus.b;
      c_d = bus.cin;
      cnt_d = '0;
      state_d = RUN;
    end else state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
      rco_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      rco_q <= rco_d;
    end
  end
endmodule

// File: tb/tb_serial_adder_ctl.sv
// tb_serial_adder_ctl: directed and random additions against an arithmetic reference model.
module tb_serial_adder_ctl;
  logic clk = 1'b0, reset = 1'b1;
  int errors = 0, checks = 0;
  logic [7:0] cur_a, cur_b, prev_sum;
  logic cur_cin, prev_cout;
  serial_adder_ctl_if #(.WIDTH(8)) bus8();
  serial_adder_ctl_if #(.WIDTH(1)) bus1();
  serial_adder_ctl #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  serial_adder_ctl #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  // full-adder cells: XOR sum, NAND-NAND carry
  assign bus8.fa_s = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_c;
  assign bus8.fa_co = ~(~(bus8.fa_a & bus8.fa_b) & ~(bus8.fa_c & (bus8.fa_a ^ bus8.fa_b)));
  assign bus1.fa_s = bus1.fa_a ^ bus1.fa_b ^ bus1.fa_c;
  assign bus1.fa_co = ~(~(bus1.fa_a & bus1.fa_b) & ~(bus1.fa_c & (bus1.fa_a ^ bus1.fa_b)));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    cur_a = a;
    cur_b = b;
    cur_cin = cin;
    bus8.a = a;
    bus8.b = b;
    bus8.cin = cin;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
    bus8.cin = 1'($urandom);
  endtask

  task automatic finish_op(input int inject);
    logic [8:0] exp9;
    logic [32:0] part;
    logic [7:0] mask;
    exp9 = 9'(cur_a) + 9'(cur_b) + 9'(cur_cin);
    for (int i = 0; i < 8; i++) begin
      mask = 8'((1 << i) - 1);
      part = 33'(cur_a & mask) + 33'(cur_b & mask) + 33'(cur_cin);
      chk("run_busy", 32'(bus8.busy), 1);
      chk("run_done", 32'(bus8.done), 0);
      chk("fa_a", 32'(bus8.fa_a), 32'(cur_a[i]));
      chk("fa_b", 32'(bus8.fa_b), 32'(cur_b[i]));
      chk("fa_c", 32'(bus8.fa_c), 32'(part[i]));
      chk("run_sum_held", 32'(bus8.sum), 32'(prev_sum));
      chk("run_cout_held", 32'(bus8.cout), 32'(prev_cout));
      if (i == inject) begin
        bus8.start = 1'b1;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.cin = 1'($urandom);
      end
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
    end
    chk("done_pulse", 32'(bus8.done), 1);
    chk("done_busy", 32'(bus8.busy), 0);
    chk("sum", 32'(bus8.sum), 32'(exp9[7:0]));
    chk("cout", 32'(bus8.cout), 32'(exp9[8]));
    chk("fa_quiet", 32'({bus8.fa_a, bus8.fa_b, bus8.fa_c}), 0);
    prev_sum = exp9[7:0];
    prev_cout = exp9[8];
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    chk("idle_done", 32'(bus8.done), 0);
    chk("idle_busy", 32'(bus8.busy), 0);
    chk("idle_sum", 32'(bus8.sum), 32'(prev_sum));
    chk("idle_cout", 32'(bus8.cout), 32'(prev_cout));
  endtask

  initial begin
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.cin = 1'b0;
    bus1.start = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.cin = 1'b0;
    prev_sum = '0;
    prev_cout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus8.busy), 0);
    chk("rst_done", 32'(bus8.done), 0);
    chk("rst_sum", 32'(bus8.sum), 0);
    chk("rst_cout", 32'(bus8.cout), 0);
    chk("rst_fa", 32'({bus8.fa_a, bus8.fa_b, bus8.fa_c}), 0);
    chk("rst_w1", 32'({bus1.busy, bus1.done, bus1.sum, bus1.cout}), 0);
    reset = 1'b0;
    idle_cycle();
    begin_op(8'h5A, 8'h3C, 1'b0);
    finish_op(-1);
    idle_cycle();
    begin_op(8'hFF, 8'h01, 1'b0);
    finish_op(-1);
    idle_cycle();
    begin_op(8'hFF, 8'hFF, 1'b1);
    finish_op(-1);
    begin_op(8'h01, 8'h02, 1'b0);
    finish_op(-1);
    idle_cycle();
    begin_op(8'h12, 8'h34, 1'b1);
    finish_op(3);
    idle_cycle();
    idle_cycle();
    for (int n = 0; n < 24; n++) begin
      begin_op(8'($urandom), 8'($urandom), 1'($urandom));
      finish_op(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
    begin_op(8'hA7, 8'h6E, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    prev_sum = '0;
    prev_cout = 1'b0;
    chk("abort_busy", 32'(bus8.busy), 0);
    chk("abort_done", 32'(bus8.done), 0);
    chk("abort_sum", 32'(bus8.sum), 0);
    chk("abort_cout", 32'(bus8.cout), 0);
    chk("abort_fa", 32'({bus8.fa_a, bus8.fa_b, bus8.fa_c}), 0);
    repeat (10) idle_cycle();
    bus1.a = 1'b1;
    bus1.b = 1'b1;
    bus1.cin = 1'b1;
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    chk("w1_busy", 32'(bus1.busy), 1);
    chk("w1_fa", 32'({bus1.fa_a, bus1.fa_b, bus1.fa_c}), 32'h7);
    @(posedge clk);
    #1;
    chk("w1_done", 32'(bus1.done), 1);
    chk("w1_busy_off", 32'(bus1.busy), 0);
    chk("w1_sum", 32'(bus1.sum), 1);
    chk("w1_cout", 32'(bus1.cout), 1);
    @(posedge clk);
    #1;
    chk("w1_done_once", 32'(bus1.done), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
